// File: rtl/mips_pkg.sv
// mips_pkg -- shared types and constants for the mips core memory subsystem.
//   arb_state_t : mem_arbiter FSM encoding (IDLE, BUSY_I, BUSY_D)
//   ARB_CNT_W   : width of the arbiter latency and starvation counters
package mips_pkg;

  localparam int unsigned ARB_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter -- single-port memory arbiter sharing one unified memory between
// the fetch unit (I-port) and the load/store unit (D-port).
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_req/i_addr                  fetch request (held until i_ready) and address
//   i_rdata/i_ready               fetch data and one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata     data request (held until d_ready), store flag,
//                                 address and store data
//   d_rdata/d_ready               load data and one-cycle completion pulse
//   mem_en/mem_we/mem_addr/
//   mem_wdata                     memory strobe (one cycle per access), write
//                                 enable, address and write data
//   mem_rdata                     memory read data
//
// Parameters: MEM_LAT (1..15) read latency, STARVE_LIMIT (1..15) maximum
// consecutive D grants while a fetch is pending.
//
// Timeline: request sampled at grant edge -> mem_en for one cycle -> ready
// pulse MEM_LAT cycles after the mem_en cycle, while still in BUSY_x with the
// latency counter at zero. The following cycle is IDLE, so a requester that
// still holds req during its ready cycle is never granted twice.
module mem_arbiter
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MEM_LAT      = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ARB_CNT_W-1:0] LAT_INIT   = ARB_CNT_W'(MEM_LAT);
  localparam logic [ARB_CNT_W-1:0] STARVE_MAX = ARB_CNT_W'(STARVE_LIMIT);
  localparam logic [ARB_CNT_W-1:0] CNT_ONE    = ARB_CNT_W'(1);

  arb_state_t state_q, state_d;

  logic [ARB_CNT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [ARB_CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              i_ready_q, i_ready_d;
  logic              d_ready_q, d_ready_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic grant_i, grant_d;

  // State register (all sequential state of the arbiter)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_ready_q    <= 1'b0;
      d_ready_q    <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_ready_q    <= i_ready_d;
      d_ready_q    <= d_ready_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // Next-state logic: grants are decided only in IDLE, no preemption.
  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_req && (starve_cnt_q < STARVE_MAX)) begin
          grant_d = 1'b1;
          state_d = BUSY_D;
        end else if (i_req) begin
          grant_i = 1'b1;
          state_d = BUSY_I;
        end else if (d_req) begin
          // Counter saturated but no fetch pending: serve D anyway.
          grant_d = 1'b1;
          state_d = BUSY_D;
        end
      end
      BUSY_I, BUSY_D: begin
        // Counter at zero marks the ready cycle; leave after it.
        if (lat_cnt_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    mem_en_d     = 1'b0;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_ready_d    = 1'b0;
    d_ready_d    = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;

    if (grant_i) begin
      mem_en_d     = 1'b1;
      mem_we_d     = 1'b0;
      mem_addr_d   = i_addr;
      lat_cnt_d    = LAT_INIT;
      starve_cnt_d = '0;
    end

    if (grant_d) begin
      mem_en_d    = 1'b1;
      mem_we_d    = d_we;
      mem_addr_d  = d_addr;
      mem_wdata_d = d_wdata;
      lat_cnt_d   = LAT_INIT;
      if (!i_req) begin
        starve_cnt_d = '0;
      end else if (starve_cnt_q != STARVE_MAX) begin
        starve_cnt_d = starve_cnt_q + CNT_ONE;
      end
    end

    // The decrement to zero captures read data and raises the ready pulse,
    // so the pulse lands while the FSM still sits in BUSY_x.
    if ((state_q != IDLE) && (lat_cnt_q != '0)) begin
      lat_cnt_d = lat_cnt_q - CNT_ONE;
      if (lat_cnt_q == CNT_ONE) begin
        if (state_q == BUSY_I) begin
          i_ready_d = 1'b1;
          i_rdata_d = mem_rdata;
        end else begin
          d_ready_d = 1'b1;
          d_rdata_d = mem_rdata;
        end
      end
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- self-checking bench for mem_arbiter. Four instances with
// MEM_LAT = 1, 3, 4, 15 share clock and reset; each has its own requesters.
// The memory model returns mem_addr ^ MAGIC, so expected read data follows
// from the requested address alone.
module tb_mem_arbiter;

  localparam int N = 4;
  localparam int LATS [N] = '{1, 3, 4, 15};
  localparam logic [31:0] MAGIC = 32'h2008_0045;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        i_req     [N];
  logic [31:0] i_addr    [N];
  logic [31:0] i_rdata   [N];
  logic        i_ready   [N];
  logic        d_req     [N];
  logic        d_we      [N];
  logic [31:0] d_addr    [N];
  logic [31:0] d_wdata   [N];
  logic [31:0] d_rdata   [N];
  logic        d_ready   [N];
  logic        mem_en    [N];
  logic        mem_we    [N];
  logic [31:0] mem_addr  [N];
  logic [31:0] mem_wdata [N];
  logic [31:0] mem_rdata [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    assign mem_rdata[g] = mem_addr[g] ^ MAGIC;
    mem_arbiter #(
      .ADDR_W(32),
      .DATA_W(32),
      .MEM_LAT(LATS[g]),
      .STARVE_LIMIT(4)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .i_req(i_req[g]),
      .i_addr(i_addr[g]),
      .i_rdata(i_rdata[g]),
      .i_ready(i_ready[g]),
      .d_req(d_req[g]),
      .d_we(d_we[g]),
      .d_addr(d_addr[g]),
      .d_wdata(d_wdata[g]),
      .d_rdata(d_rdata[g]),
      .d_ready(d_ready[g]),
      .mem_en(mem_en[g]),
      .mem_we(mem_we[g]),
      .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g])
    );
  end

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic void push(input bit is_d, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata);
    sb.push_back(exp_t'{is_d, we, addr, wdata});
  endfunction

  // Drive i_n fetches and d_n data accesses on instance idx (requests held
  // until their ready), checking every mem_en and ready against the queue.
  // Called and returns at a falling edge with the arbiter idle.
  task automatic run(input int idx, input int i_n, input int d_n,
                     input logic [31:0] ibase, input logic [31:0] dbase,
                     input bit dwe, input string tag);
    int i_done = 0;
    int d_done = 0;
    int en_cnt = 0;
    int en_cyc = -1000;
    int drv_cyc;
    i_req[idx]   = (i_n > 0);
    i_addr[idx]  = ibase;
    d_req[idx]   = (d_n > 0);
    d_we[idx]    = dwe;
    d_addr[idx]  = dbase;
    d_wdata[idx] = 32'hDEAD_BEEF;
    drv_cyc = cyc;
    for (int t = 0; t < 400 && sb.size() != 0; t++) begin
      @(negedge clk);
      if (mem_en[idx]) begin
        en_cnt++;
        chk({tag, "/en_once"}, en_cnt, 1);
        chk({tag, "/mem_addr"}, mem_addr[idx], sb[0].addr);
        chk({tag, "/mem_we"}, 32'(mem_we[idx]), 32'(sb[0].we));
        if (sb[0].we) chk({tag, "/mem_wdata"}, mem_wdata[idx], sb[0].wdata);
        en_cyc = cyc;
      end
      if (i_ready[idx] || d_ready[idx]) begin
        exp_t e;
        e = sb.pop_front();
        chk({tag, "/ready_port"}, {30'b0, i_ready[idx], d_ready[idx]}, e.is_d ? 32'd1 : 32'd2);
        chk({tag, "/en_to_ready"}, cyc - en_cyc, LATS[idx]);
        if (i_n + d_n == 1) chk({tag, "/req_to_ready"}, cyc - drv_cyc, LATS[idx] + 1);
        if (!e.we) chk({tag, "/rdata"}, e.is_d ? d_rdata[idx] : i_rdata[idx], e.addr ^ MAGIC);
        en_cnt = 0;
        en_cyc = -1000;
        if (i_ready[idx]) begin
          i_done++;
          if (i_done == i_n) i_req[idx] = 1'b0;
          else i_addr[idx] = ibase + 32'(4 * i_done);
        end
        if (d_ready[idx]) begin
          d_done++;
          if (d_done == d_n) d_req[idx] = 1'b0;
          else begin
            d_addr[idx]  = dbase + 32'(4 * d_done);
            d_wdata[idx] = 32'hDEAD_BEEF + 32'(d_done);
          end
        end
      end
    end
    chk({tag, "/outstanding"}, sb.size(), 0);
    sb.delete();
    i_req[idx] = 1'b0;
    d_req[idx] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      i_req[k] = 1'b0; i_addr[k] = '0; d_req[k] = 1'b0; d_we[k] = 1'b0;
      d_addr[k] = '0; d_wdata[k] = '0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    chk("reset/mem_en", mem_en[0], 0);
    chk("reset/mem_we", mem_we[0], 0);
    chk("reset/mem_addr", mem_addr[0], 0);
    chk("reset/mem_wdata", mem_wdata[0], 0);
    chk("reset/i_ready", i_ready[0], 0);
    chk("reset/d_ready", d_ready[0], 0);
    chk("reset/i_rdata", i_rdata[0], 0);
    chk("reset/d_rdata", d_rdata[0], 0);
    rst = 1'b0;
    @(negedge clk);

    // Single fetch: 0x40 -> 0x2008_0005
    push(0, 0, 32'h40, '0);
    run(0, 1, 0, 32'h40, '0, 0, "fetch");
    chk("fetch/i_rdata_hold", i_rdata[0], 32'h2008_0005);

    // Store
    push(1, 1, 32'h100, 32'hDEAD_BEEF);
    run(0, 0, 1, '0, 32'h100, 1, "store");

    // Load
    push(1, 0, 32'h180, '0);
    run(0, 0, 1, '0, 32'h180, 0, "load");

    // Simultaneous requests: D first, then I
    push(1, 0, 32'h300, '0);
    push(0, 0, 32'h80, '0);
    run(0, 1, 1, 32'h80, 32'h300, 0, "simul");

    // Starvation guard: 4 D grants, 1 I grant, D resumes
    for (int k = 0; k < 4; k++) push(1, 0, 32'h200 + 32'(4 * k), '0);
    push(0, 0, 32'hC0, '0);
    for (int k = 4; k < 6; k++) push(1, 0, 32'h200 + 32'(4 * k), '0);
    run(0, 1, 6, 32'hC0, 32'h200, 0, "starve");

    // Requester drops req and changes address after grant
    begin
      int w = 0;
      i_req[0] = 1'b1; i_addr[0] = 32'h700;
      @(negedge clk);
      i_req[0] = 1'b0; i_addr[0] = 32'h7F0;
      while (!i_ready[0] && w < 20) begin @(negedge clk); w++; end
      chk("drop/i_ready", i_ready[0], 1);
      chk("drop/i_rdata", i_rdata[0], 32'h700 ^ MAGIC);
      @(negedge clk);
    end

    // Latency sweep on MEM_LAT = 4 and 15
    for (int idx = 2; idx < 4; idx++) begin
      push(0, 0, 32'h500, '0);
      run(idx, 1, 0, 32'h500, '0, 0, "sweep_i");
      push(1, 0, 32'h600, '0);
      run(idx, 0, 1, '0, 32'h600, 0, "sweep_d");
      push(1, 1, 32'h640, 32'hDEAD_BEEF);
      run(idx, 0, 1, '0, 32'h640, 1, "sweep_st");
    end

    // Reset mid-operation on MEM_LAT = 3
    push(1, 0, 32'h44, '0);
    run(1, 0, 1, '0, 32'h44, 0, "rst_pre");
    begin
      int w = 0;
      int seen = 0;
      d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h400; d_wdata[1] = 32'h1234_5678;
      while (!mem_en[1] && w < 20) begin @(negedge clk); w++; end
      chk("rstmid/en_seen", mem_en[1], 1);
      rst = 1'b1;
      @(negedge clk);
      chk("rstmid/mem_en", mem_en[1], 0);
      chk("rstmid/mem_we", mem_we[1], 0);
      chk("rstmid/mem_addr", mem_addr[1], 0);
      chk("rstmid/mem_wdata", mem_wdata[1], 0);
      chk("rstmid/i_ready", i_ready[1], 0);
      chk("rstmid/d_ready", d_ready[1], 0);
      chk("rstmid/i_rdata", i_rdata[1], 0);
      chk("rstmid/d_rdata", d_rdata[1], 0);
      rst = 1'b0;
      d_req[1] = 1'b0;
      repeat (8) begin
        @(negedge clk);
        if (d_ready[1] || mem_en[1]) seen++;
      end
      chk("rstmid/no_activity", seen, 0);
    end
    push(1, 0, 32'h480, '0);
    run(1, 0, 1, '0, 32'h480, 0, "rst_post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
